// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// DmemResponder: single-port word memory behind a valid/ready request and
// response handshake, with a fixed number of wait cycles inserted between
// accepting a request and presenting its response.
//
// Parameters
//   WAIT_CYCLES : wait cycles between acceptance and response (0..15)
//   DEPTH_LOG2  : log2 of the number of 32-bit words held
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : initiator presents a request
//   req_ready  : responder is idle and can accept a request
//   req_write  : 1 = store word, 0 = load word
//   req_addr   : byte address
//   req_wdata  : store data
//   resp_valid : response available
//   resp_ready : initiator consumes the response
//   resp_rdata : load data (0 for stores and errors)
//   resp_err   : request was misaligned or out of range
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         Words    = 1 << DEPTH_LOG2;
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    stateT                  state;
    stateT                  nextState;
    logic [3:0]             waitCount;

    logic                   latWrite;
    logic [DEPTH_LOG2-1:0]  latIdx;
    logic [31:0]            latWdata;
    logic                   latErr;

    logic                   accept;
    logic                   enterResp;
    logic                   reqErr;
    logic [DEPTH_LOG2-1:0]  reqIdx;

    logic                   effWrite;
    logic [DEPTH_LOG2-1:0]  effIdx;
    logic [31:0]            effWdata;
    logic                   effErr;

    logic [31:0]            mem [Words];

    // Decode the incoming address: word index plus the misaligned /
    // out-of-range error flag.
    always_comb begin
        accept = req_valid && req_ready;
        reqIdx = req_addr[DEPTH_LOG2+1:2];
        reqErr = (req_addr[1:0] != 2'b00) || (|req_addr[31:DEPTH_LOG2+2]);
    end

    // With zero wait cycles RESP is entered on the accept edge itself, before
    // the latched copy exists, so the live request is used in IDLE and the
    // latched copy everywhere else.
    always_comb begin
        if (state == IDLE) begin
            effWrite = req_write;
            effIdx   = reqIdx;
            effWdata = req_wdata;
            effErr   = reqErr;
        end else begin
            effWrite = latWrite;
            effIdx   = latIdx;
            effWdata = latWdata;
            effErr   = latErr;
        end
        enterResp = (state != RESP) && (nextState == RESP);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: the counter is loaded on acceptance and RESP is
    // entered on the edge where it reads 1.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (waitCount == 4'd1) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Handshake outputs follow directly from the state.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    // Request capture and wait counter; inputs are ignored outside IDLE
    // because accept can only fire there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCount <= 4'd0;
            latWrite  <= 1'b0;
            latIdx    <= '0;
            latWdata  <= 32'd0;
            latErr    <= 1'b0;
        end else if (accept) begin
            waitCount <= WaitInit;
            latWrite  <= req_write;
            latIdx    <= reqIdx;
            latWdata  <= req_wdata;
            latErr    <= reqErr;
        end else if (state == WAIT) begin
            waitCount <= waitCount - 4'd1;
        end
    end

    // Response data is captured once on entry to RESP and then held until
    // the response is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (enterResp) begin
            resp_err   <= effErr;
            resp_rdata <= (!effWrite && !effErr) ? mem[effIdx] : 32'd0;
        end
    end

    // Storage is deliberately not reset. A store commits only on the edge
    // entering RESP, so a reset during WAIT drops it.
    always_ff @(posedge clk) begin
        if (enterResp && effWrite && !effErr) begin
            mem[effIdx] <= effWdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// TbDmemResponder: drives two responders (two wait cycles and zero wait
// cycles) through directed and random load/store transactions and compares
// every response against a word-array model of the memory.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [1:0]  reqWrite;
    logic [1:0][31:0] reqAddr;
    logic [1:0][31:0] reqWdata;
    logic [1:0]  respValid;
    logic [1:0]  respReady;
    logic [1:0][31:0] respRdata;
    logic [1:0]  respErr;

    int          vectorCount = 0;
    int          missCount   = 0;

    logic [31:0] model   [2][64];
    bit          written [2][64];

    dmem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) dutSlow (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid[0]),
        .req_ready  (reqReady[0]),
        .req_write  (reqWrite[0]),
        .req_addr   (reqAddr[0]),
        .req_wdata  (reqWdata[0]),
        .resp_valid (respValid[0]),
        .resp_ready (respReady[0]),
        .resp_rdata (respRdata[0]),
        .resp_err   (respErr[0])
    );

    dmem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) dutFast (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid[1]),
        .req_ready  (reqReady[1]),
        .req_write  (reqWrite[1]),
        .req_addr   (reqAddr[1]),
        .req_wdata  (reqWdata[1]),
        .resp_valid (respValid[1]),
        .resp_ready (respReady[1]),
        .resp_rdata (respRdata[1]),
        .resp_err   (respErr[1])
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // A request is bad when it is not word aligned or lies beyond 64 words.
    function automatic logic refErr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    // One complete transaction on responder `which`, entered and left on a
    // falling edge with the responder idle. `hold` is how many response
    // cycles the initiator stalls before consuming (0 = ready tied high).
    task automatic applyStimulus(input int which, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold, input string name);
        int          waitCycles;
        int          cyc;
        logic        expErr;
        logic [31:0] expData;
        waitCycles = (which == 0) ? 2 : 0;
        expErr     = refErr(addr);
        expData    = (wr || expErr) ? 32'd0 : model[which][addr / 4];

        checkOutput({name, ".readyIdle"}, {31'd0, reqReady[which]}, 32'd1);
        reqValid[which]  = 1'b1;
        reqWrite[which]  = wr;
        reqAddr[which]   = addr;
        reqWdata[which]  = wdata;
        respReady[which] = (hold == 0);
        @(posedge clk);
        #1;
        // Junk store held valid while busy; it must never be taken.
        reqWrite[which] = 1'b1;
        reqAddr[which]  = 32'($urandom_range(0, 63)) * 4;
        reqWdata[which] = $urandom;

        @(negedge clk);
        cyc = 1;
        while (!respValid[which] && cyc < 40) begin
            checkOutput({name, ".readyBusy"}, {31'd0, reqReady[which]}, 32'd0);
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, ".latency"}, 32'(cyc), 32'(waitCycles + 1));
        checkOutput({name, ".err"}, {31'd0, respErr[which]}, {31'd0, expErr});
        checkOutput({name, ".rdata"}, respRdata[which], expData);

        for (int h = 0; h < hold; h++) begin
            checkOutput({name, ".holdValid"}, {31'd0, respValid[which]}, 32'd1);
            checkOutput({name, ".holdReady"}, {31'd0, reqReady[which]}, 32'd0);
            checkOutput({name, ".holdRdata"}, respRdata[which], expData);
            checkOutput({name, ".holdErr"}, {31'd0, respErr[which]}, {31'd0, expErr});
            @(negedge clk);
        end
        respReady[which] = 1'b1;
        @(negedge clk);
        checkOutput({name, ".doneValid"}, {31'd0, respValid[which]}, 32'd0);
        checkOutput({name, ".doneReady"}, {31'd0, reqReady[which]}, 32'd1);
        respReady[which] = 1'b0;
        reqValid[which]  = 1'b0;

        if (wr && !expErr) begin
            model[which][addr / 4]   = wdata;
            written[which][addr / 4] = 1'b1;
        end
    endtask

    // Directed scenarios first, then a randomized mix on both responders.
    initial begin
        int          which;
        logic        wr;
        logic [31:0] addr;
        int          kind;

        reset     = 1'b0;
        reqValid  = '0;
        reqWrite  = '0;
        reqAddr   = '0;
        reqWdata  = '0;
        respReady = '0;

        #2;
        for (int w = 0; w < 2; w++) begin
            checkOutput("reset.ready", {31'd0, reqReady[w]}, 32'd1);
            checkOutput("reset.valid", {31'd0, respValid[w]}, 32'd0);
            checkOutput("reset.err", {31'd0, respErr[w]}, 32'd0);
            checkOutput("reset.rdata", respRdata[w], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(0, 1'b1, 32'd84, 32'd7, 0, "store84");
        applyStimulus(0, 1'b0, 32'd84, 32'd0, 0, "load84");
        applyStimulus(0, 1'b0, 32'd84, 32'd0, 4, "load84Stall");
        applyStimulus(0, 1'b1, 32'h55, 32'hDEAD_BEEF, 0, "storeMisaligned");
        applyStimulus(0, 1'b0, 32'd84, 32'd0, 0, "load84Again");
        applyStimulus(0, 1'b0, 32'h400, 32'd0, 0, "loadOutOfRange");

        applyStimulus(1, 1'b1, 32'd0, 32'd5, 0, "fastStore0");
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 0, "fastLoad0");

        // Store aborted by reset during WAIT must not land in memory.
        applyStimulus(0, 1'b1, 32'd8, 32'd3, 0, "store8");
        applyStimulus(0, 1'b0, 32'd84, 32'd0, 0, "load84PreReset");
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 32'd8;
        reqWdata[0] = 32'h1234_5678;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(negedge clk);
        checkOutput("abort.inWait", {31'd0, reqReady[0]}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("abort.ready", {31'd0, reqReady[0]}, 32'd1);
        checkOutput("abort.valid", {31'd0, respValid[0]}, 32'd0);
        checkOutput("abort.err", {31'd0, respErr[0]}, 32'd0);
        checkOutput("abort.rdata", respRdata[0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 1'b0, 32'd8, 32'd0, 0, "load8AfterReset");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("abort.noStray", {31'd0, respValid[0]}, 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            which = $urandom_range(0, 1);
            wr    = 1'($urandom_range(0, 1));
            kind  = $urandom_range(0, 3);
            if (kind == 0) begin
                addr = $urandom;
            end else if (kind == 1) begin
                addr = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            end else begin
                addr = 32'($urandom_range(0, 63)) * 4;
            end
            if (!wr && !refErr(addr) && !written[which][addr / 4]) begin
                wr = 1'b1;
            end
            applyStimulus(which, wr, addr, $urandom, $urandom_range(0, 3), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
